// File: rtl/dyser_config_ctrl.sv
// Configuration load sequencer for the DySER tile array: drain fabric, shift NUM_WORDS words, settle, report done.
// Latency: accepted word appears on conf_en/conf_data one cycle later; start->done is NUM_WORDS+SETTLE_CYCLES+3 cycles minimum.
// Backpressure: cfg_ready is high only in SHIFT without abort; host bubbles simply hold the chain (conf_en=0).

`ifndef PATH_WIDTH
`define PATH_WIDTH 32
`endif

module dyser_config_ctrl #(
  parameter int CONF_WIDTH    = `PATH_WIDTH + 1,
  parameter int NUM_WORDS     = 64,
  parameter int SETTLE_CYCLES = 4,
  parameter int DRAIN_TIMEOUT = 255
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               abort,
  input  logic                               fabric_idle,
  input  logic                               cfg_valid,
  input  logic [CONF_WIDTH-1:0]              cfg_data,
  output logic                               cfg_ready,
  output logic                               conf_en,
  output logic [CONF_WIDTH-1:0]              conf_data,
  output logic                               fabric_hold,
  output logic                               busy,
  output logic                               done,
  output logic                               err,
  output logic [$clog2(NUM_WORDS+1)-1:0]     words_loaded
);

  localparam int WL_W = $clog2(NUM_WORDS + 1);
  localparam int DT_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam int ST_W = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRAIN  = 3'd1,
    SHIFT  = 3'd2,
    SETTLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t          state;
  logic [DT_W-1:0] drain_timer;
  logic [ST_W-1:0] settle_cnt;

  // Host handshake: abort blocks the accept in the same cycle so a colliding word is dropped.
  assign cfg_ready = (state == SHIFT) && !abort;
  assign busy      = (state != IDLE);

  // Load sequencer: state, counters and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      drain_timer  <= '0;
      settle_cnt   <= '0;
      conf_en      <= 1'b0;
      conf_data    <= '0;
      fabric_hold  <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
    end else begin
      // Shift enable and done are single-cycle pulses unless re-armed below.
      conf_en <= 1'b0;
      done    <= 1'b0;
      if (abort && (state == DRAIN || state == SHIFT || state == SETTLE)) begin
        // Partial count and err are kept for the host to inspect.
        state       <= IDLE;
        fabric_hold <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state        <= DRAIN;
              err          <= 1'b0;
              words_loaded <= '0;
              drain_timer  <= '0;
              fabric_hold  <= 1'b1;
            end
          end
          DRAIN: begin
            if (fabric_idle) begin
              state <= SHIFT;
            end else if (drain_timer == DT_W'(DRAIN_TIMEOUT - 1)) begin
              // This is the DRAIN_TIMEOUT-th busy cycle: give up.
              err         <= 1'b1;
              state       <= IDLE;
              fabric_hold <= 1'b0;
            end else begin
              drain_timer <= drain_timer + DT_W'(1);
            end
          end
          SHIFT: begin
            if (cfg_valid) begin
              conf_en      <= 1'b1;
              conf_data    <= cfg_data;
              words_loaded <= words_loaded + WL_W'(1);
              if (words_loaded == WL_W'(NUM_WORDS - 1)) begin
                state      <= SETTLE;
                settle_cnt <= '0;
              end
            end
          end
          SETTLE: begin
            // First SETTLE cycle carries the final shift; the SETTLE_CYCLES idle cycles follow it.
            if (settle_cnt == ST_W'(SETTLE_CYCLES)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              settle_cnt <= settle_cnt + ST_W'(1);
            end
          end
          DONE: begin
            state       <= IDLE;
            fabric_hold <= 1'b0;
          end
          default: begin
            state       <= IDLE;
            fabric_hold <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
